pipe_stage_skid: RTL and testbench

//  Generic parametrised pipeline-stage register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_skid.sv | 154 +++++++++++++++
 tb/tb_pipe_stage_skid.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with a valid/ready handshake and an optional
// one-entry skid buffer. Control and datapath payloads travel on separate
// buses: a flush turns the stage into a bubble by clearing control and
// validity, and leaves datapath bits untouched.
//
// Handshake: an entry moves across a boundary on a rising clock edge where
// valid and ready are both high on that boundary. A producer that asserts
// valid keeps valid and its payload stable until the transfer happens. Ready
// may be asserted with or without valid.
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [1:0]        state_o
);

    // The encoding equals the number of held entries, so occupancy is the state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              state_q, state_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic                in_ready_q, in_ready_d;
    logic                in_xfer;
    logic                out_xfer;

    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_ctrl_o  = out_valid_o ? main_ctrl_q : '0;
    assign out_data_o  = main_data_q;
    assign occupancy_o = state_q;
    assign state_o     = state_q;
    assign stall_cnt_o = stall_q;

    assign in_xfer  = in_valid_i & in_ready_o;
    assign out_xfer = out_valid_o & out_ready_i;

    // Ready: registered flag with the skid buffer, pass-through of downstream
    // ready without it. Reset gating keeps ready low while rst_i is held and
    // lets it rise in the very first cycle after reset.
    always_comb begin
        if (SKID != 0) begin
            in_ready_o = in_ready_q & ~rst_i;
        end else begin
            in_ready_o = ~rst_i & (~out_valid_o | out_ready_i);
        end
    end

    // Next-state, payload movement and stall counting.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        stall_d     = stall_q;

        if (out_valid_o && !out_ready_i && stall_q != CNT_MAX) begin
            stall_d = stall_q + CNT_ONE;
        end

        if (flush_i) begin
            // Squash: any held entry and a concurrent input are discarded;
            // datapath bits are left as they are.
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = in_ctrl_i;
                        main_data_d = in_data_i;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_ctrl_d = in_ctrl_i;
                        main_data_d = in_data_i;
                    end else if (out_xfer) begin
                        state_d     = ST_EMPTY;
                        main_ctrl_d = '0;
                    end else if (in_xfer && SKID != 0) begin
                        state_d     = ST_TWO;
                        skid_ctrl_d = in_ctrl_i;
                        skid_data_d = in_data_i;
                    end
                end
                ST_TWO: begin
                    if (out_xfer) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = '0;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_ctrl_d = '0;
                    skid_ctrl_d = '0;
                end
            endcase
        end

        in_ready_d = (state_d != ST_TWO);
    end

    // State and payload registers; reset wins over flush and handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            stall_q     <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            stall_q     <= stall_d;
            in_ready_q  <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: one instance with the skid buffer and a
// 4-bit stall counter, one instance without the skid buffer.
module tb_pipe_stage_skid;

    localparam int DW = 32;
    localparam int CW = 8;
    localparam int NW = 4;

    logic          clk;
    logic          rst;

    // Instance A: SKID=1
    logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [CW-1:0] a_in_ctrl, a_out_ctrl;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [1:0]    a_occ, a_state;
    logic [NW-1:0] a_stall;

    // Instance B: SKID=0
    logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [CW-1:0] b_in_ctrl, b_out_ctrl;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [1:0]    b_occ, b_state;
    logic [NW-1:0] b_stall;

    int checks = 0;
    int errors = 0;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(a_flush),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
        .in_ctrl_i(a_in_ctrl), .in_data_i(a_in_data),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
        .out_ctrl_o(a_out_ctrl), .out_data_o(a_out_data),
        .occupancy_o(a_occ), .stall_cnt_o(a_stall), .state_o(a_state)
    );

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(NW)) dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(b_flush),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
        .in_ctrl_i(b_in_ctrl), .in_data_i(b_in_data),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
        .out_ctrl_o(b_out_ctrl), .out_data_o(b_out_data),
        .occupancy_o(b_occ), .stall_cnt_o(b_stall), .state_o(b_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge; outputs are looked at 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [CW-1:0] c, input logic [DW-1:0] d);
        a_in_valid = 1'b1;
        a_in_ctrl  = c;
        a_in_data  = d;
    endtask

    initial begin
        // ---- 1: reset with in_valid high ----
        rst = 1'b1;
        a_flush = 1'b0; a_out_ready = 1'b0;
        b_flush = 1'b0; b_out_ready = 1'b0;
        send_a(8'hFF, 32'h55);
        b_in_valid = 1'b1; b_in_ctrl = 8'hFF; b_in_data = 32'h55;
        step();
        step();
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_ctrl", 64'(a_out_ctrl), 64'd0);
        chk("rst_out_data", 64'(a_out_data), 64'd0);
        chk("rst_stall", 64'(a_stall), 64'd0);
        chk("rst_occ", 64'(a_occ), 64'd0);
        chk("rst_in_ready", 64'(a_in_ready), 64'd0);
        chk("rst_b_in_ready", 64'(b_in_ready), 64'd0);
        rst = 1'b0;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(a_in_ready), 64'd1);
        chk("post_rst_b_in_ready", 64'(b_in_ready), 64'd1);

        // ---- 2: streaming 1,2,3 with out_ready high ----
        a_out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            send_a(8'(8'h10 + i), 32'(i));
            step();
            chk($sformatf("stream_valid_%0d", i), 64'(a_out_valid), 64'd1);
            chk($sformatf("stream_data_%0d", i), 64'(a_out_data), 64'(i));
            chk($sformatf("stream_ctrl_%0d", i), 64'(a_out_ctrl), 64'(8'h10 + i));
            chk($sformatf("stream_occ_%0d", i), 64'(a_occ), 64'd1);
            chk($sformatf("stream_rdy_%0d", i), 64'(a_in_ready), 64'd1);
        end
        a_in_valid = 1'b0;
        step();
        chk("stream_drain_valid", 64'(a_out_valid), 64'd0);
        chk("stream_drain_ctrl", 64'(a_out_ctrl), 64'd0);
        chk("stream_stall", 64'(a_stall), 64'd0);

        // ---- 3: skid fill with downstream stalled ----
        a_out_ready = 1'b0;
        send_a(8'h0A, 32'hA);
        step();
        chk("skid_one_occ", 64'(a_occ), 64'd1);
        chk("skid_one_rdy", 64'(a_in_ready), 64'd1);
        chk("skid_one_data", 64'(a_out_data), 64'hA);
        send_a(8'h0B, 32'hB);
        step();
        chk("skid_two_occ", 64'(a_occ), 64'd2);
        chk("skid_two_rdy", 64'(a_in_ready), 64'd0);
        chk("skid_two_data", 64'(a_out_data), 64'hA);
        chk("skid_two_ctrl", 64'(a_out_ctrl), 64'h0A);
        a_in_valid = 1'b0;
        step();
        chk("skid_hold_data", 64'(a_out_data), 64'hA);
        chk("skid_hold_occ", 64'(a_occ), 64'd2);
        chk("skid_hold_stall", 64'(a_stall), 64'd2);
        a_out_ready = 1'b1;
        step();
        chk("skid_drain1_data", 64'(a_out_data), 64'hB);
        chk("skid_drain1_ctrl", 64'(a_out_ctrl), 64'h0B);
        chk("skid_drain1_occ", 64'(a_occ), 64'd1);
        chk("skid_drain1_rdy", 64'(a_in_ready), 64'd1);
        step();
        chk("skid_drain2_valid", 64'(a_out_valid), 64'd0);
        chk("skid_drain2_stall", 64'(a_stall), 64'd2);

        // ---- 4: flush while full, with a concurrent input ----
        a_out_ready = 1'b0;
        send_a(8'h01, 32'h1);
        step();
        send_a(8'h02, 32'h2);
        step();
        chk("flush_pre_occ", 64'(a_occ), 64'd2);
        a_flush = 1'b1;
        send_a(8'hCC, 32'hC);
        step();
        chk("flush_valid", 64'(a_out_valid), 64'd0);
        chk("flush_ctrl", 64'(a_out_ctrl), 64'd0);
        chk("flush_occ", 64'(a_occ), 64'd0);
        chk("flush_rdy", 64'(a_in_ready), 64'd1);
        chk("flush_stall", 64'(a_stall), 64'd4);
        a_flush = 1'b0;
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("flush_no_c_%0d", i), 64'(a_out_valid), 64'd0);
        end

        // ---- 5: stall counter saturation ----
        a_out_ready = 1'b0;
        send_a(8'h77, 32'h77);
        step();
        a_in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("sat_stall", 64'(a_stall), 64'd15);
        chk("sat_hold_data", 64'(a_out_data), 64'h77);
        chk("sat_hold_ctrl", 64'(a_out_ctrl), 64'h77);
        a_out_ready = 1'b1;
        step();
        chk("sat_drain_valid", 64'(a_out_valid), 64'd0);
        chk("sat_keep_stall", 64'(a_stall), 64'd15);

        // ---- 6: SKID=0 back-to-back ----
        b_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_ctrl = 8'h21; b_in_data = 32'h21;
        #1;
        chk("b_empty_rdy", 64'(b_in_ready), 64'd1);
        step();
        chk("b_one_valid", 64'(b_out_valid), 64'd1);
        chk("b_one_rdy", 64'(b_in_ready), 64'd0);
        chk("b_one_occ", 64'(b_occ), 64'd1);
        b_in_ctrl = 8'h22; b_in_data = 32'h22;
        step();
        chk("b_hold_data", 64'(b_out_data), 64'h21);
        chk("b_hold_ctrl", 64'(b_out_ctrl), 64'h21);
        b_out_ready = 1'b1;
        #1;
        chk("b_comb_rdy", 64'(b_in_ready), 64'd1);
        step();
        chk("b_b2b_valid", 64'(b_out_valid), 64'd1);
        chk("b_b2b_data", 64'(b_out_data), 64'h22);
        b_in_ctrl = 8'h23; b_in_data = 32'h23;
        step();
        chk("b_b2b2_data", 64'(b_out_data), 64'h23);
        chk("b_b2b2_occ", 64'(b_occ), 64'd1);
        b_in_valid = 1'b0;
        step();
        chk("b_drain_valid", 64'(b_out_valid), 64'd0);
        chk("b_stall", 64'(b_stall), 64'd1);

        // ---- stall counter cleared only by reset ----
        rst = 1'b1;
        step();
        chk("rerst_stall", 64'(a_stall), 64'd0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
